// File: rtl/ghost_regbank_pkg.sv
// ghost_regbank_pkg: shared address map, decode regions and the region decoder
// used by the ghostbus register bank.
package ghost_regbank_pkg;

  localparam logic [63:0] ADDR_ID   = 64'h000;
  localparam logic [63:0] ADDR_SNAP = 64'h002;
  localparam logic [63:0] ADDR_CTRL = 64'h010;
  localparam logic [63:0] ADDR_CNT  = 64'h020;

  localparam int unsigned NCH_MAX = 16;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_ID,
    REG_SNAP,
    REG_CTRL,
    REG_CNT,
    REG_RAM
  } region_e;

  // The full (zero-extended) address is compared, so upper bits never alias.
  function automatic region_e decode_region(
    input logic [63:0] addr,
    input int unsigned nch,
    input logic [63:0] ram_base,
    input int unsigned ram_aw,
    input logic        snap_en
  );
    region_e r;
    r = REG_NONE;
    if (addr == ADDR_ID)
      r = REG_ID;
    else if (snap_en && (addr == ADDR_SNAP))
      r = REG_SNAP;
    else if ((addr >= ADDR_CTRL) && (addr < ADDR_CTRL + 64'(nch)))
      r = REG_CTRL;
    else if ((addr >= ADDR_CNT) && (addr < ADDR_CNT + 64'(nch)))
      r = REG_CNT;
    else if ((addr >= ram_base) && (addr < ram_base + (64'd1 << ram_aw)))
      r = REG_RAM;
    return r;
  endfunction

endpackage

// File: rtl/ghost_regbank_ram.sv
// ghost_regbank_ram: single-port scratch RAM with registered, read-before-write
// output. Contents are deliberately not reset.
module ghost_regbank_ram #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  // Write and read share the edge; the read sees the old word.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/ghost_regbank.sv
// ghost_regbank: multi-channel control registers, saturating event counters and
// a scratch RAM behind one ghostbus slave port. Reads take exactly two cycles.
// Optional macro GHOST_REGBANK_SNAPSHOT_EN adds the SNAP register at 0x002 and
// per-channel shadow copies of the counters that counter reads then return.
module ghost_regbank
  import ghost_regbank_pkg::*;
#(
  parameter int unsigned AW       = 24,
  parameter int unsigned DW       = 32,
  parameter int unsigned NCH      = 4,
  parameter int unsigned RAM_AW   = 6,
  parameter int unsigned RAM_BASE = 'h100,
  parameter int unsigned ID       = 'h6B62
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    evt_in,
  output logic [NCH*DW-1:0] ctrl_out,
  input  logic [AW-1:0]     gb_addr,
  input  logic [DW-1:0]     gb_wdata,
  input  logic              gb_we,
  input  logic              gb_re,
  output logic [DW-1:0]     gb_rdata,
  output logic              gb_rvalid
);

`ifdef GHOST_REGBANK_SNAPSHOT_EN
  localparam logic SNAP_EN = 1'b1;
`else
  localparam logic SNAP_EN = 1'b0;
`endif

  region_e       region;
  logic [3:0]    ch_idx;
  logic [DW-1:0] ctrl_q [NCH];
  logic [DW-1:0] cnt_q  [NCH];
  logic [NCH-1:0] evt_cur;
  logic [NCH-1:0] evt_prev;
  logic [NCH-1:0] evt_rise;
  logic          wr_ctrl;
  logic          wr_cnt;
  logic          ram_we;
  logic          ram_re;
  logic [DW-1:0] ram_q;
  logic [DW-1:0] rd_sel;
  logic          s1_valid;
  logic          s1_is_ram;
  logic [DW-1:0] s1_data;

  assign region   = decode_region(64'(gb_addr), NCH, 64'(RAM_BASE), RAM_AW, SNAP_EN);
  assign ch_idx   = gb_addr[3:0];
  assign wr_ctrl  = gb_we && (region == REG_CTRL);
  assign wr_cnt   = gb_we && (region == REG_CNT);
  assign ram_we   = gb_we && (region == REG_RAM);
  assign ram_re   = gb_re && (region == REG_RAM);
  assign evt_rise = evt_cur & ~evt_prev;

  for (genvar g = 0; g < NCH; g++) begin : g_ctrl_out
    assign ctrl_out[g*DW +: DW] = ctrl_q[g];
  end

  // Control registers: plain R/W, visible on ctrl_out the cycle after the write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) ctrl_q[c] <= '0;
    end else begin
      for (int c = 0; c < NCH; c++)
        if (wr_ctrl && (ch_idx == 4'(c))) ctrl_q[c] <= gb_wdata;
    end
  end

  // Event input register plus one history stage for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_cur  <= '0;
      evt_prev <= '0;
    end else begin
      evt_cur  <= evt_in;
      evt_prev <= evt_cur;
    end
  end

  // Saturating counters; a clear that coincides with an edge lands on 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) cnt_q[c] <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (wr_cnt && (ch_idx == 4'(c)))
          cnt_q[c] <= evt_rise[c] ? DW'(1) : '0;
        else if (evt_rise[c] && (cnt_q[c] != '1))
          cnt_q[c] <= cnt_q[c] + 1'b1;
      end
    end
  end

`ifdef GHOST_REGBANK_SNAPSHOT_EN
  logic [DW-1:0] shd_q [NCH];
  logic          wr_snap;

  assign wr_snap = gb_we && (region == REG_SNAP);

  // Shadow copy takes the counts as they stood before this edge's update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) shd_q[c] <= '0;
    end else if (wr_snap) begin
      for (int c = 0; c < NCH; c++) shd_q[c] <= cnt_q[c];
    end
  end
`endif

  // Stage-1 register mux, driven from pre-write state (read-before-write).
  always_comb begin
    rd_sel = '0;
    case (region)
      REG_ID: rd_sel = DW'(ID);
      REG_CTRL: begin
        for (int c = 0; c < NCH; c++)
          if (ch_idx == 4'(c)) rd_sel = ctrl_q[c];
      end
      REG_CNT: begin
        for (int c = 0; c < NCH; c++)
`ifdef GHOST_REGBANK_SNAPSHOT_EN
          if (ch_idx == 4'(c)) rd_sel = shd_q[c];
`else
          if (ch_idx == 4'(c)) rd_sel = cnt_q[c];
`endif
      end
      default: rd_sel = '0;
    endcase
  end

  ghost_regbank_ram #(
    .DW (DW),
    .AW (RAM_AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (gb_addr[RAM_AW-1:0]),
    .wdata (gb_wdata),
    .rdata (ram_q)
  );

  // Stage 1: capture decode result alongside the RAM's registered read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_is_ram <= 1'b0;
      s1_data   <= '0;
    end else begin
      s1_valid  <= gb_re;
      s1_is_ram <= ram_re;
      s1_data   <= rd_sel;
    end
  end

  // Stage 2: output register; data is forced to zero outside the valid pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gb_rvalid <= 1'b0;
      gb_rdata  <= '0;
    end else begin
      gb_rvalid <= s1_valid;
      gb_rdata  <= s1_valid ? (s1_is_ram ? ram_q : s1_data) : '0;
    end
  end

endmodule

// File: tb/tb_ghost_regbank.sv
// tb_ghost_regbank: scoreboard bench for ghost_regbank. Stimulus pushes expected
// read data (from a behavioural model of the address map) into a queue; a
// monitor on the falling edge pops and compares each gb_rvalid beat.
// Build with GHOST_REGBANK_SNAPSHOT_EN to exercise the snapshot variant (DW=8).
module tb_ghost_regbank;

  localparam int AW = 24;
`ifdef GHOST_REGBANK_SNAPSHOT_EN
  localparam int DW   = 8;
  localparam bit SNAP = 1'b1;
`else
  localparam int DW   = 32;
  localparam bit SNAP = 1'b0;
`endif
  localparam int NCH       = 4;
  localparam int RAM_AW    = 6;
  localparam int RAM_BASE  = 'h100;
  localparam int ID        = 'h6B62;
  localparam int RAM_WORDS = 1 << RAM_AW;
  localparam logic [DW-1:0] MAXV = '1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NCH-1:0]    evt_in = '0;
  logic [NCH*DW-1:0] ctrl_out;
  logic [AW-1:0]     gb_addr = '0;
  logic [DW-1:0]     gb_wdata = '0;
  logic              gb_we = 1'b0;
  logic              gb_re = 1'b0;
  logic [DW-1:0]     gb_rdata;
  logic              gb_rvalid;

  ghost_regbank #(
    .AW(AW), .DW(DW), .NCH(NCH), .RAM_AW(RAM_AW), .RAM_BASE(RAM_BASE), .ID(ID)
  ) dut (
    .clk(clk), .rst_n(rst_n), .evt_in(evt_in), .ctrl_out(ctrl_out),
    .gb_addr(gb_addr), .gb_wdata(gb_wdata), .gb_we(gb_we), .gb_re(gb_re),
    .gb_rdata(gb_rdata), .gb_rvalid(gb_rvalid)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
    int            addr;
  } exp_t;
  exp_t expq[$];
  exp_t mon_e;

  // Behavioural model of the register map.
  logic [DW-1:0]  ctrl_m [NCH];
  logic [DW-1:0]  cnt_m  [NCH];
  logic [DW-1:0]  shd_m  [NCH];
  logic [DW-1:0]  ram_m  [RAM_WORDS];
  logic [NCH-1:0] hist1 = '0;  // evt_in driven one cycle ago
  logic [NCH-1:0] hist2 = '0;  // evt_in driven two cycles ago

  function automatic logic [DW-1:0] exp_read(input int a);
    if (a == 0) return DW'(ID);
    if (a >= 'h10 && a < 'h10 + NCH) return ctrl_m[a - 'h10];
    if (a >= 'h20 && a < 'h20 + NCH) return SNAP ? shd_m[a - 'h20] : cnt_m[a - 'h20];
    if (a >= RAM_BASE && a < RAM_BASE + RAM_WORDS) return ram_m[a - RAM_BASE];
    return '0;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      ctrl_m[c] = '0;
      cnt_m[c]  = '0;
      shd_m[c]  = '0;
    end
    hist1 = '0;
    hist2 = '0;
  endtask

  task automatic chk_ctrl();
    logic [NCH*DW-1:0] e;
    for (int c = 0; c < NCH; c++) e[c*DW +: DW] = ctrl_m[c];
    checks++;
    if (ctrl_out !== e) begin
      errors++;
      $display("FAIL ctrl_out: got %h expected %h", ctrl_out, e);
    end
  endtask

  // One bus cycle; called just after a rising edge, returns just after the next.
  task automatic step(input logic [NCH-1:0] evt, input bit we, input bit re,
                      input int a, input logic [DW-1:0] wd);
    logic [NCH-1:0] rise;
    chk_ctrl();
    evt_in   = evt;
    gb_we    = we;
    gb_re    = re;
    gb_addr  = AW'(a);
    gb_wdata = wd;
    if (re) expq.push_back('{exp_read(a), cyc, a});
    // An input level reaches the edge detector one cycle after it is driven.
    rise = hist1 & ~hist2;
    if (we && SNAP && a == 2)
      for (int c = 0; c < NCH; c++) shd_m[c] = cnt_m[c];
    for (int c = 0; c < NCH; c++) begin
      if (we && a == 'h20 + c) cnt_m[c] = rise[c] ? DW'(1) : '0;
      else if (rise[c] && cnt_m[c] != MAXV) cnt_m[c] = cnt_m[c] + 1'b1;
    end
    if (we && a >= 'h10 && a < 'h10 + NCH) ctrl_m[a - 'h10] = wd;
    if (we && a >= RAM_BASE && a < RAM_BASE + RAM_WORDS) ram_m[a - RAM_BASE] = wd;
    hist2 = hist1;
    hist1 = evt;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(evt_in, 1'b0, 1'b0, 0, '0);
  endtask

  task automatic rd(input int a);
    step(evt_in, 1'b0, 1'b1, a, '0);
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    step(evt_in, 1'b1, 1'b0, a, d);
  endtask

  task automatic pulse(input int ch, input int n);
    logic [NCH-1:0] v;
    for (int i = 0; i < n; i++) begin
      v = evt_in; v[ch] = 1'b1; step(v, 1'b0, 1'b0, 0, '0);
      v = evt_in; v[ch] = 1'b0; step(v, 1'b0, 1'b0, 0, '0);
    end
  endtask

  function automatic int pick_addr();
    case ($urandom_range(0, 7))
      0: return 0;
      1: return 2;
      2: return 'h10 + int'($urandom_range(0, NCH));
      3: return 'h20 + int'($urandom_range(0, NCH));
      4, 5: return RAM_BASE + int'($urandom_range(0, RAM_WORDS));
      6: return 'h800000 | ('h10 + int'($urandom_range(0, NCH - 1)));
      default: return int'($urandom_range(0, 'h1FF));
    endcase
  endfunction

  // Monitor: every falling edge either consumes one expected beat or checks idle.
  always @(negedge clk) begin
    checks++;
    if (!rst_n) begin
      if (gb_rvalid !== 1'b0 || gb_rdata !== '0) begin
        errors++;
        $display("FAIL reset_outputs: rvalid=%b rdata=%h, expected 0/0", gb_rvalid, gb_rdata);
      end
    end else if (gb_rvalid === 1'b1) begin
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rvalid: rdata=%h at cycle %0d, no read outstanding", gb_rdata, cyc);
      end else begin
        mon_e = expq.pop_front();
        if (gb_rdata !== mon_e.data || cyc != mon_e.cyc + 2) begin
          errors++;
          $display("FAIL read addr=%h: got %h at cycle %0d, expected %h at cycle %0d",
                   mon_e.addr, gb_rdata, cyc, mon_e.data, mon_e.cyc + 2);
        end
      end
    end else if (gb_rvalid !== 1'b0 || gb_rdata !== '0) begin
      errors++;
      $display("FAIL idle_rdata: rvalid=%b rdata=%h, expected 0/0", gb_rvalid, gb_rdata);
    end
  end

  initial begin
    int drain;
    logic [NCH-1:0] v;
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_ctrl();
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // ID, control registers at reset, unmapped and aliased addresses.
    rd('h000);
    for (int a = 'h10; a < 'h10 + NCH; a++) rd(a);
    rd('h014); rd('h0FF); rd('h800000); rd('h800010);
    idle(3);

    // CTRL[2] write, one-cycle-later ctrl_out check, readback.
    wr('h012, DW'(32'hDEADBEEF));
    idle(1);
    rd('h012);
    idle(2);

    // Five edges, then clear coinciding with a sixth, then a held level.
    pulse(1, 5);
    idle(2);
    rd('h021);
    v = evt_in; v[1] = 1'b1; step(v, 1'b0, 1'b0, 0, '0);
    step(v, 1'b1, 1'b0, 'h021, '0);
    v[1] = 1'b0; step(v, 1'b0, 1'b0, 0, '0);
    idle(2);
    rd('h021);
    v[1] = 1'b1;
    for (int i = 0; i < 10; i++) step(v, 1'b0, 1'b0, 0, '0);
    v[1] = 1'b0; step(v, 1'b0, 1'b0, 0, '0);
    idle(2);
    rd('h021);

    // RAM fill, back-to-back readout, same-cycle write/read.
    for (int i = 0; i < RAM_WORDS; i++) wr(RAM_BASE + i, DW'((RAM_BASE + i) ^ 'hA5));
    for (int i = 0; i < RAM_WORDS; i++) rd(RAM_BASE + i);
    step(evt_in, 1'b1, 1'b1, RAM_BASE + 5, DW'(32'h1234_5678));
    rd(RAM_BASE + 5);
    rd(RAM_BASE + RAM_WORDS);
    step(evt_in, 1'b1, 1'b1, 'h013, DW'(32'hCAFE_F00D));
    rd('h013);
    idle(3);

`ifdef GHOST_REGBANK_SNAPSHOT_EN
    // Saturation at 255, snapshot, then live count diverges from the shadow.
    pulse(0, 300);
    idle(2);
    rd('h020);
    wr('h002, '0);
    rd('h020);
    wr('h020, '0);
    pulse(0, 3);
    idle(2);
    rd('h020);
    wr('h002, '0);
    idle(1);
    rd('h020);
    idle(3);
`else
    wr('h002, DW'(32'hFFFF_FFFF));
    rd('h002);
    idle(3);
`endif

    // Randomised traffic against the model.
    for (int i = 0; i < 500; i++) begin
      v = evt_in;
      if ($urandom_range(0, 3) == 0) v = NCH'($urandom());
      step(v, ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 1), pick_addr(), DW'($urandom()));
    end
    idle(3);

    // Mid-operation reset: read in flight, nonzero control and count state.
    wr('h010, DW'(32'h0000_005A));
    pulse(3, 2);
    idle(2);
    step('0, 1'b0, 1'b1, 'h010, '0);
    rst_n = 1'b0;
    expq.delete();
    model_reset();
    #1;
    chk_ctrl();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(3);
    for (int c = 0; c < NCH; c++) begin
      rd('h10 + c);
      rd('h20 + c);
    end

    drain = 0;
    while (expq.size() != 0 && drain < 20) begin
      idle(1);
      drain++;
    end
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d reads outstanding, expected 0", expq.size());
    end
    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ghost_regbank.md
Name: ghost_regbank

Overview:
- Parametrised host-accessible register bank, the next generation of the hand-instantiated ghostbus peripheral.
- Exposes N channels of writable control registers, N saturating event counters and a host-accessible RAM on one explicit ghostbus slave port.
- Reads use a uniform, fully pipelined latency.
- Sits under the ghostbus decoder wherever a module needs multi-channel control/status plus a scratch RAM.

Parameters:
- AW, 24, host address width (word addresses)
- DW, 32, host data width; control register and counter width
- NCH, 4, channel count, 1..16
- RAM_AW, 6, RAM depth is 2**RAM_AW words of DW bits
- RAM_BASE, 'h100, RAM base address; must be aligned to 2**RAM_AW and must be >= 'h040
- ID, 'h6B62, constant returned at address 0x000

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- evt_in  in  NCH  per-channel event inputs, synchronous to clk
- ctrl_out  out  NCH*DW  control registers; channel c occupies bits [c*DW +: DW]
- gb_addr  in  AW  host word address
- gb_wdata  in  DW  host write data
- gb_we  in  1  write strobe, one cycle per write
- gb_re  in  1  read strobe, one cycle per read
- gb_rdata  out  DW  read data, valid only while gb_rvalid is high
- gb_rvalid  out  1  read-data valid pulse

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Address map:
  - 0x000: ID, read-only.
  - 0x010+c: CTRL[c], R/W.
  - 0x020+c: CNT[c]. Reading returns the count; any write clears it.
  - RAM_BASE .. RAM_BASE+2**RAM_AW-1: RAM.
  - Unmapped reads return 0. Unmapped writes are ignored.
- Reset values: ctrl_out=0, CNT=0, gb_rdata=0, gb_rvalid=0, edge-detect registers=0. RAM contents are not reset.
- Reads:
  - Fixed latency of 2 cycles: gb_re at cycle t gives gb_rvalid=1 at t+2, for every region.
  - Fully pipelined, so back-to-back gb_re every cycle gives back-to-back gb_rvalid.
  - Stage 1: address decode, register mux selection, RAM read.
  - Stage 2: output register.
  - gb_rdata returns 0 whenever gb_rvalid=0.
- Writes:
  - Take effect at the clk edge where gb_we=1. ctrl_out updates 1 cycle after gb_we.
  - No write acknowledge.
- gb_we and gb_re asserted in the same cycle at the same address: the read returns the pre-write value (read-before-write), for registers and RAM alike.
- Event counters:
  - evt_in is registered once; a rising edge is prev=0, cur=1.
  - CNT[c] increments by 1 per rising edge, saturating at 2**DW-1 (no wrap).
  - A write to CNT[c] in the same cycle as an edge on channel c leaves CNT[c]=1 (clear, then count).
  - A level held high counts once.
- Reset mid-operation: the in-flight read pipeline is flushed, and no gb_rvalid is produced for reads accepted before reset.
- Address widths: gb_addr bits above those needed for decode are compared in full. There is no aliasing.

Optional Feature:
- Macro: GHOST_REGBANK_SNAPSHOT_EN
- With the macro defined:
  - New register SNAP at 0x002. Writing any value copies all CNT[c] into shadow registers SHD[c] in one cycle.
  - Reads of 0x020+c return SHD[c], not the live count.
  - Writes to 0x020+c still clear the live CNT[c].
  - SHD resets to 0.
- Without the macro: 0x002 is unmapped, there is no shadow storage, and counter reads return the live CNT[c].

Decomposition:
- Package ghost_regbank_pkg holds:
  - address offsets: ADDR_ID=0x000, ADDR_SNAP=0x002, ADDR_CTRL=0x010, ADDR_CNT=0x020
  - NCH_MAX=16
  - a function returning the decode region enum (REG_ID, REG_SNAP, REG_CTRL, REG_CNT, REG_RAM, REG_NONE)
- One sub-module, ghost_regbank_ram: single-port RAM, depth 2**RAM_AW, with synchronous read-before-write. It forms pipeline stage 1.

Test Plan:
- Reset, then read 0x000 → gb_rvalid exactly 2 cycles after gb_re, gb_rdata='h6B62; reads of 0x010..0x013 return 0.
- Write CTRL[2]=32'hDEADBEEF → ctrl_out[95:64]=DEADBEEF one cycle later; other channels stay 0; readback of 0x012 matches.
- Drive 5 rising edges on evt_in[1] → read 0x021 returns 5. Write 0x021 in the same cycle as a 6th edge → subsequent read returns 1. Hold evt_in[1] high for 10 cycles → count increments by 1 only.
- Write RAM words 0x100..0x13F with value addr^0xA5, then issue 64 back-to-back reads → 64 consecutive gb_rvalid cycles with matching data. Same-cycle write and read of 0x105 returns the old value.
- With GHOST_REGBANK_SNAPSHOT_EN, DW=8: count 300 edges on channel 0 → CNT saturates at 255. Write 0x002, then add 3 edges → read 0x020 returns 255 and SHD stays fixed. Without the macro, read 0x002 returns 0.
- Assert rst_n low one cycle after a gb_re → no gb_rvalid appears; ctrl_out and counters return to 0 asynchronously.
